// File: rtl/display_sequencer_pkg.sv
// Shared types and timing defaults for the display sequencer and display stage.
package display_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_D1   = 2'd1,
    S_D2   = 2'd2,
    S_GAP  = 2'd3
  } disp_seq_state_t;

  localparam int DISP_VALUE_W = 16;

  // Default timing, shared with the display stage (100 MHz clock).
  localparam int DEF_HALF_CYCLES = 50_000_000;
  localparam int DEF_GAP_CYCLES  = 10_000_000;
  localparam int DEF_FIFO_DEPTH  = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_sequencer_if.sv
// Producer handshake and display-stage outputs of the display sequencer.
interface display_sequencer_if
  import display_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                    in_valid;
  logic [7:0]              in_value;
  logic                    in_ready;
  logic                    flush;
  logic                    start_pulse;
  logic                    mid_pulse;
  logic                    end_pulse;
  logic [DISP_VALUE_W-1:0] disp_value;
  logic                    busy;
  logic [LEVEL_W-1:0]      level;

  // Producer / consumer side (the environment around the sequencer).
  modport master (
    output in_valid, in_value, flush,
    input  in_ready, start_pulse, mid_pulse, end_pulse, disp_value, busy, level
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_value, flush,
    output in_ready, start_pulse, mid_pulse, end_pulse, disp_value, busy, level
  );

endinterface

// File: rtl/display_sequencer_fifo.sv
// Synchronous FIFO with wrap-bit pointers; occupancy is write count minus read count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      level_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // The extra pointer bit distinguishes full from empty; DEPTH is a power of 2.
  assign level_s   = wr_ptr_r - rd_ptr_r;
  assign full      = (level_s == (AW+1)'(DEPTH));
  assign empty     = (level_s == (AW+1)'(0));
  assign level     = level_s;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];
  assign push_ok_s = push & ~full & ~clear;
  assign pop_ok_s  = pop & ~empty & ~clear;

  // Pointer update; clear drops every queued entry at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= (AW+1)'(0);
      rd_ptr_r <= (AW+1)'(0);
    end else if (clear) begin
      wr_ptr_r <= (AW+1)'(0);
      rd_ptr_r <= (AW+1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// Replays buffered 8-bit values on the two-digit display: start, mid and end
// pulses plus the latched value bus, with a blank gap between values.
module display_sequencer
  import display_pkg::*;
#(
  parameter int HALF_CYCLES = DEF_HALF_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input logic                clk,
  input logic                reset,
  display_sequencer_if.slave bus
);

  localparam int CNT_MAX = max_int(HALF_CYCLES, GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  // Load values make each phase last exactly its cycle count; a zero gap
  // still spends one cycle in S_GAP.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : CNT_W'(0);

  disp_seq_state_t         state_r;
  disp_seq_state_t         state_next_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_next_s;
  logic                    ready_en_r;
  logic                    start_r;
  logic                    mid_r;
  logic                    end_r;
  logic                    busy_r;
  logic [DISP_VALUE_W-1:0] disp_value_r;
  logic                    start_s;
  logic                    mid_s;
  logic                    end_s;
  logic                    pop_s;
  logic                    push_s;
  logic                    in_ready_s;
  logic [7:0]              fifo_dout_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [LEVEL_W-1:0]      fifo_level_s;

  // ready_en_r holds in_ready low through reset and for the release cycle.
  assign in_ready_s = ready_en_r & ~fifo_full_s & ~bus.flush;
  assign push_s     = bus.in_valid & in_ready_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (bus.flush),
    .push  (push_s),
    .pop   (pop_s),
    .din   (bus.in_value),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level_s)
  );

  // Next state, counter reload and pulse decode; flush overrides everything.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    pop_s        = 1'b0;
    start_s      = 1'b0;
    mid_s        = 1'b0;
    end_s        = 1'b0;
    if (bus.flush) begin
      state_next_s = S_IDLE;
      cnt_next_s   = CNT_W'(0);
      if ((state_r == S_D1) || (state_r == S_D2)) begin
        end_s = 1'b1;
      end else begin
        end_s = 1'b0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (!fifo_empty_s) begin
            pop_s        = 1'b1;
            start_s      = 1'b1;
            state_next_s = S_D1;
            cnt_next_s   = HALF_LOAD;
          end else begin
            cnt_next_s   = CNT_W'(0);
          end
        end
        S_D1: begin
          if (cnt_r == CNT_W'(0)) begin
            mid_s        = 1'b1;
            state_next_s = S_D2;
            cnt_next_s   = HALF_LOAD;
          end else begin
            cnt_next_s   = cnt_r - CNT_W'(1);
          end
        end
        S_D2: begin
          if (cnt_r == CNT_W'(0)) begin
            end_s        = 1'b1;
            state_next_s = S_GAP;
            cnt_next_s   = GAP_LOAD;
          end else begin
            cnt_next_s   = cnt_r - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_r == CNT_W'(0)) begin
            state_next_s = S_IDLE;
            cnt_next_s   = CNT_W'(0);
          end else begin
            cnt_next_s   = cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_next_s = S_IDLE;
          cnt_next_s   = CNT_W'(0);
        end
      endcase
    end
  end

  // State, counter and registered outputs; pulses leave on the transition edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      cnt_r        <= CNT_W'(0);
      ready_en_r   <= 1'b0;
      start_r      <= 1'b0;
      mid_r        <= 1'b0;
      end_r        <= 1'b0;
      busy_r       <= 1'b0;
      disp_value_r <= {DISP_VALUE_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      ready_en_r <= 1'b1;
      start_r    <= start_s;
      mid_r      <= mid_s;
      end_r      <= end_s;
      busy_r     <= (state_next_s != S_IDLE);
      if (pop_s) begin
        disp_value_r <= {8'h00, fifo_dout_s};
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.start_pulse = start_r;
  assign bus.mid_pulse   = mid_r;
  assign bus.end_pulse   = end_r;
  assign bus.disp_value  = disp_value_r;
  assign bus.busy        = busy_r;
  assign bus.level       = fifo_level_s;

endmodule
